rr_lock_arbiter: RTL and testbench
==================================

// Module: rr_lock_arbiter
// PURPOSE
//  Parametrised, clocked round-robin arbiter with grant locking for the router crossbar.
//  Grants one of SIZE requesters and holds the grant for a whole packet until release.
//  Optional hold-timeout (HOLD_MAX). Registered one-hot and encoded grant outputs.
//  Sits between the input-buffer request lines and the switch-control/crossbar select logic.
// PARAMETERS
//  SIZE      `NPORT  number of requesters, >=2
//  HOLD_MAX  0       max cycles a grant may be held; 0 = unlimited
//  IDX_W     $clog2(SIZE)  encoded grant width (derived, localparam)
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-low; all state cleared while low
//  req            in   SIZE   per-requester request, level
//  enable         in   1      arbitration strobe; a new grant is issued only when high
//  release        in   1      holder signals end of packet (tail flit sent)
//  grant_valid    out  1      a grant is currently held
//  grant_onehot   out  SIZE   one-hot grant; all-zero when !grant_valid
//  grant_idx      out  IDX_W  encoded holder; holds last value when !grant_valid
//  timeout        out  1      one-cycle pulse: grant withdrawn by HOLD_MAX
// BEHAVIOUR
//  Reset: grant_valid=0, grant_onehot=0, grant_idx=0, timeout=0, state=IDLE,
//   last_ptr=SIZE-1 so port 0 has first priority, hold_cnt=0.
//  Search: candidate order last_ptr+1, +2, ... wrapping SIZE-1 -> 0; last_ptr checked last.
//   First set req bit in that order wins. All index arithmetic is modulo SIZE, not 2**IDX_W.
//  FSM, 2 states:
//   IDLE:  enable && |req at edge t -> GRANT at t+1, grant_* registered (latency 1),
//          last_ptr <= winner, hold_cnt <= 1. Otherwise stay in IDLE.
//   GRANT: end condition = release | !req[grant_idx] | (HOLD_MAX!=0 && hold_cnt==HOLD_MAX).
//          No end condition -> hold grant, hold_cnt++ (saturating).
//          End condition and enable && other requests pending -> back-to-back: new winner,
//           searched from the current holder, is granted at t+1 with no bubble.
//           The current holder is eligible only if it is the sole requester.
//          End condition, no new winner -> IDLE at t+1, grant_valid=0.
//  timeout=1 for exactly the cycle after the forced end, only if release and the request
//   drop were both absent. Release has priority over timeout.
//  Grant never changes while in GRANT without an end condition, whatever enable or req do.
//  enable is ignored for holding; it gates only new grants.
//  release in IDLE is ignored.
//  last_ptr updates only when a grant is issued.
//  Simultaneous release + enable + new req in the same cycle: back-to-back rule applies.
//  req all-zero with enable=1: no grant, pointer unchanged.
//  Reset mid-grant: outputs drop asynchronously to reset values. Priority restarts at port 0.
//  HOLD_MAX=1: every grant lasts one cycle and timeout pulses unless release accompanies it.
// STRUCTURE
//  defines.vh: `NPORT (existing), `ARB_IDLE/`ARB_GRANT state encodings.
//  Sub-module rr_priority_pick (combinational): inputs req, base pointer; outputs found,
//   winner index. Instantiated once, base = last_ptr in IDLE, grant_idx in GRANT.
//  Top: FSM, hold counter, output registers, onehot decode from registered grant_idx.
// TESTING (SIZE=5 unless noted)
//  1 Reset release, req=5'b10100, enable=1 -> next edge grant_idx=2, onehot=00100, valid=1.
//  2 Rotation: after 1, release with req=10100 -> back-to-back grant_idx=4 with no bubble;
//    release again -> grant_idx=2.
//  3 Lock: holder 2, req toggles 11111, enable=1 for 10 cycles, no release
//    -> grant_idx stays 2 throughout.
//  4 Timeout: HOLD_MAX=4, holder 1 with req[1] held, no release -> valid for exactly 4 cycles,
//    then timeout=1 for 1 cycle; grant goes to the next requester, or to IDLE if none.
//  5 Drop: holder 3, req[3] falls, other req=0 -> valid=0 next cycle, state IDLE, timeout=0.
//  6 Async reset asserted mid-grant (between edges) -> outputs 0 immediately.
//    After reset, req=11111 -> grant_idx=0.
//  All: assert onehot==(valid ? 1<<grant_idx : 0), $onehot0(grant_onehot) every cycle.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and defaults for the crossbar round-robin lock arbiter.
package rr_lock_arbiter_pkg;

    localparam int unsigned NPORT = 5;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority search: first set request after base, base itself last.
module rr_priority_pick #(
    parameter int unsigned SIZE = 5,
    localparam int unsigned IDX_W = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]  req,
    input  logic [IDX_W-1:0] base,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    int cand;

    // Walk from the lowest-priority offset down so the nearest requester wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = int'(SIZE); k >= 1; k--) begin
            cand = (int'(base) + k) % int'(SIZE);
            if (req[cand]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks a grant for a whole packet, with optional hold timeout.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int unsigned SIZE     = NPORT,
    parameter int unsigned HOLD_MAX = 0,
    localparam int unsigned IDX_W   = $clog2(SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SIZE-1:0]  req,
    input  logic             enable,
    input  logic             pkt_release,
    output logic             grant_valid,
    output logic [SIZE-1:0]  grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    localparam int unsigned CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    arb_state_e       state_q;
    logic [IDX_W-1:0] last_ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] base;
    logic             hold_hit;
    logic             holder_req;
    logic             end_cond;
    logic             issue;

    // While holding, search from the holder so it can only win again as sole requester.
    assign base       = (state_q == StGrant) ? grant_idx : last_ptr_q;
    assign hold_hit   = (HOLD_MAX != 0) && (hold_cnt_q == CNT_W'(HOLD_MAX));
    assign holder_req = req[grant_idx];
    assign end_cond   = pkt_release || !holder_req || hold_hit;
    assign issue      = enable && found && ((state_q == StIdle) || end_cond);

    rr_priority_pick #(
        .SIZE (SIZE)
    ) u_pick (
        .req    (req),
        .base   (base),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            last_ptr_q  <= IDX_W'(SIZE - 1);
            hold_cnt_q  <= '0;
        end else begin
            timeout <= (state_q == StGrant) && hold_hit && !pkt_release && holder_req;
            if (issue) begin
                state_q     <= StGrant;
                grant_valid <= 1'b1;
                grant_idx   <= winner;
                last_ptr_q  <= winner;
                hold_cnt_q  <= CNT_W'(1);
            end else if (state_q == StGrant) begin
                if (end_cond) begin
                    state_q     <= StIdle;
                    grant_valid <= 1'b0;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench: two arbiters (unlimited hold and HOLD_MAX=4) against a queue-fed model.
module tb_rr_lock_arbiter;

    localparam int N = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic         enable = 1'b0;
    logic         pkt_release = 1'b0;

    logic         gv0, gv4, to0, to4;
    logic [N-1:0] oh0, oh4;
    logic [2:0]   gi0, gi4;

    int total = 0;
    int bad = 0;

    typedef struct {
        int   valid[2];
        int   idx[2];
        int   to[2];
    } exp_t;

    exp_t exp_q[$];

    int m_hold[2];
    int m_last[2];
    int m_cnt[2];
    int m_idx[2];
    int m_to[2];

    always #5 clock = ~clock;

    rr_lock_arbiter #(.SIZE(N), .HOLD_MAX(0)) dut0 (
        .clock (clock), .reset (reset), .req (req), .enable (enable),
        .pkt_release (pkt_release), .grant_valid (gv0), .grant_onehot (oh0),
        .grant_idx (gi0), .timeout (to0)
    );

    rr_lock_arbiter #(.SIZE(N), .HOLD_MAX(4)) dut4 (
        .clock (clock), .reset (reset), .req (req), .enable (enable),
        .pkt_release (pkt_release), .grant_valid (gv4), .grant_onehot (oh4),
        .grant_idx (gi4), .timeout (to4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int hold_max(input int k);
        return (k == 0) ? 0 : 4;
    endfunction

    function automatic int search(input int from, input logic [N-1:0] r);
        for (int s = 1; s <= N; s++) begin
            int c;
            c = (from + s) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = -1;
            m_last[k] = N - 1;
            m_cnt[k]  = 0;
            m_idx[k]  = 0;
            m_to[k]   = 0;
        end
    endtask

    task automatic model_grant(input int k, input int w);
        m_hold[k] = w;
        m_last[k] = w;
        m_idx[k]  = w;
        m_cnt[k]  = 1;
    endtask

    task automatic model_step(input int k, input logic [N-1:0] r, input bit en, input bit rel);
        int  w;
        bit  ending;
        bit  expired;
        m_to[k] = 0;
        if (m_hold[k] < 0) begin
            w = en ? search(m_last[k], r) : -1;
            if (w >= 0) model_grant(k, w);
        end else begin
            expired = (hold_max(k) != 0) && (m_cnt[k] == hold_max(k));
            ending  = rel || !r[m_hold[k]] || expired;
            if (!ending) begin
                m_cnt[k]++;
            end else begin
                m_to[k] = expired && !rel && r[m_hold[k]];
                w = en ? search(m_hold[k], r) : -1;
                if (w >= 0) model_grant(k, w);
                else m_hold[k] = -1;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue what both arbiters must show after the edge.
    task automatic cycle(input logic [N-1:0] r, input bit en, input bit rel);
        exp_t e;
        @(negedge clock);
        req = r;
        enable = en;
        pkt_release = rel;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, en, rel);
            e.valid[k] = (m_hold[k] >= 0) ? 1 : 0;
            e.idx[k]   = m_idx[k];
            e.to[k]    = m_to[k];
        end
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [N-1:0] onehot_of(input int v, input int idx);
        logic [N-1:0] o;
        o = '0;
        if (v != 0) o[idx] = 1'b1;
        return o;
    endfunction

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        check("onehot_inv0", 32'(oh0), 32'(gv0 ? (5'b1 << gi0) : 5'b0));
        check("onehot_inv4", 32'(oh4), 32'(gv4 ? (5'b1 << gi4) : 5'b0));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid0", 32'(gv0), 32'(e.valid[0]));
            check("valid4", 32'(gv4), 32'(e.valid[1]));
            check("timeout0", 32'(to0), 32'(e.to[0]));
            check("timeout4", 32'(to4), 32'(e.to[1]));
            check("idx0", 32'(gi0), 32'(e.idx[0]));
            check("idx4", 32'(gi4), 32'(e.idx[1]));
            check("onehot0", 32'(oh0), 32'(onehot_of(e.valid[0], e.idx[0])));
            check("onehot4", 32'(oh4), 32'(onehot_of(e.valid[1], e.idx[1])));
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_valid", 32'({gv0, gv4}), 32'(0));
        check("rst_onehot", 32'({oh0, oh4}), 32'(0));
        check("rst_idx", 32'({gi0, gi4}), 32'(0));
        check("rst_timeout", 32'({to0, to4}), 32'(0));
        reset = 1'b1;

        // First grant and back-to-back rotation.
        cycle(5'b10100, 1, 0);
        settle();
        check("t1_idx", 32'(gi0), 32'(2));
        check("t1_onehot", 32'(oh0), 32'(5'b00100));
        cycle(5'b10100, 1, 1);
        settle();
        check("t2_idx_a", 32'(gi0), 32'(4));
        check("t2_valid_a", 32'(gv0), 32'(1));
        cycle(5'b10100, 1, 1);
        settle();
        check("t2_idx_b", 32'(gi0), 32'(2));

        // Lock: holder stays put while other requests churn.
        for (int i = 0; i < 10; i++) begin
            cycle((i % 2 == 0) ? 5'b11111 : 5'b00100, 1, 0);
            settle();
            check("t3_lock", 32'({gv0, gi0}), 32'({1'b1, 3'd2}));
        end
        cycle(5'b00000, 0, 1);
        cycle(5'b00000, 0, 0);

        // Hold timeout on the HOLD_MAX=4 instance, no other requester and enable low.
        cycle(5'b00010, 1, 0);
        settle();
        check("t4_grant", 32'({gv4, gi4}), 32'({1'b1, 3'd1}));
        for (int i = 0; i < 3; i++) begin
            cycle(5'b00010, 0, 0);
            settle();
            check("t4_held", 32'({gv4, to4}), 32'({1'b1, 1'b0}));
        end
        cycle(5'b00010, 0, 0);
        settle();
        check("t4_expire", 32'({gv4, to4}), 32'({1'b0, 1'b1}));
        cycle(5'b00000, 0, 0);
        settle();
        check("t4_pulse_end", 32'(to4), 32'(0));

        // Request drop ends the grant without a timeout pulse.
        cycle(5'b01000, 1, 0);
        settle();
        check("t5_grant", 32'(gi0), 32'(3));
        cycle(5'b00000, 1, 0);
        settle();
        check("t5_drop", 32'({gv0, to0}), 32'({1'b0, 1'b0}));

        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0));
        end
        cycle(5'b00000, 0, 0);

        // Asynchronous reset between edges while a grant is held.
        cycle(5'b11111, 1, 0);
        cycle(5'b11111, 1, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async", 32'({gv0, gv4, oh0, oh4, gi0, gi4, to0, to4}), 32'(0));
        model_reset();
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        cycle(5'b11111, 1, 0);
        settle();
        check("t6_restart", 32'({gv0, gi0, gv4, gi4}), 32'({1'b1, 3'd0, 1'b1, 3'd0}));

        settle();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
